// File: rtl/seven_seg_scanner_pkg.sv
// Shared definitions for the seven-segment scanner: segment vector type,
// segment bit positions and the hex glyph table (active-high, bit0 = a).
package seven_seg_pkg;

   typedef logic [6:0] seg_t;

   localparam int SEG_A = 0;
   localparam int SEG_B = 1;
   localparam int SEG_C = 2;
   localparam int SEG_D = 3;
   localparam int SEG_E = 4;
   localparam int SEG_F = 5;
   localparam int SEG_G = 6;

   localparam seg_t SEG_TABLE [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   function automatic seg_t seg_decode(input logic [3:0] nibble);
      return SEG_TABLE[nibble];
   endfunction

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex nibble to active-high seven-segment pattern.
module hex_to_7seg
   import seven_seg_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] pattern
);

   seg_t glyph;

   assign glyph = seg_decode(nibble);

   // Place each glyph segment on its board bit position.
   assign pattern = {glyph[SEG_G], glyph[SEG_F], glyph[SEG_E], glyph[SEG_D],
                     glyph[SEG_C], glyph[SEG_B], glyph[SEG_A]};

endmodule

// File: rtl/seven_seg_scanner.sv
// Multiplexed seven-segment bank driver with blanking, 16-level PWM,
// leading-zero suppression and frame-synchronous shadow updates.
module seven_seg_scanner
   import seven_seg_pkg::*;
#(
   parameter int NUM_DIGITS     = 3,
   parameter int SCAN_DIV       = 131072,
   parameter int BLANK_CYCLES   = 256,
   parameter bit CA_ACTIVE_LOW  = 1'b1,
   parameter bit SEG_ACTIVE_LOW = 1'b1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic [NUM_DIGITS-1:0]   dp,
   input  logic [NUM_DIGITS-1:0]   digit_en,
   input  logic                    lz_suppress,
   input  logic [3:0]              brightness,
   input  logic                    update,
   output logic [NUM_DIGITS-1:0]   ca,
   output logic [6:0]              seg,
   output logic                    seg_dp,
   output logic                    frame_tick
);

   localparam int ON_LEN = (SCAN_DIV - BLANK_CYCLES) / 16;
   localparam int CW     = $clog2(SCAN_DIV + 1);
   localparam int IW     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [CW-1:0]         CNT_LAST  = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0]         BLANK_END = CW'(BLANK_CYCLES);
   localparam logic [IW-1:0]         IDX_LAST  = IW'(NUM_DIGITS - 1);
   localparam logic [NUM_DIGITS-1:0] CA_OFF    = {NUM_DIGITS{CA_ACTIVE_LOW}};
   localparam logic [6:0]            SEG_OFF   = {7{SEG_ACTIVE_LOW}};

   if ((SCAN_DIV - BLANK_CYCLES) % 16 != 0 || BLANK_CYCLES >= SCAN_DIV) begin : g_bad_timing
      $error("seven_seg_scanner: SCAN_DIV-BLANK_CYCLES must be positive and divisible by 16");
   end
   if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
      $error("seven_seg_scanner: NUM_DIGITS must be 1..8");
   end

   logic [CW-1:0]           cnt;
   logic [IW-1:0]           idx;
   logic [4*NUM_DIGITS-1:0] sh_value;
   logic [NUM_DIGITS-1:0]   sh_dp;
   logic [NUM_DIGITS-1:0]   sh_en;
   logic                    pending;

   logic [CW-1:0]         on_end;
   logic                  in_window;
   logic [3:0]            nibble;
   logic                  dp_sel;
   logic                  en_sel;
   logic                  zero_above;
   logic                  suppressed;
   logic [NUM_DIGITS-1:0] onehot;
   logic                  lit;
   logic [6:0]            pattern;

   assign on_end    = CW'(BLANK_CYCLES + (int'(brightness) + 1) * ON_LEN);
   assign in_window = (cnt >= BLANK_END) && (cnt < on_end);

   // Walk from the most significant digit down so zero_above means
   // "this digit and every digit to its left hold zero".
   always_comb begin
      nibble     = '0;
      dp_sel     = 1'b0;
      en_sel     = 1'b0;
      onehot     = '0;
      suppressed = 1'b0;
      zero_above = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         zero_above = zero_above && (sh_value[4*i +: 4] == 4'd0);
         if (idx == IW'(i)) begin
            nibble     = sh_value[4*i +: 4];
            dp_sel     = sh_dp[i];
            en_sel     = sh_en[i];
            onehot[i]  = 1'b1;
            suppressed = zero_above && (i != 0);
         end
      end
   end

   assign lit = in_window && en_sel && !(lz_suppress && suppressed);

   hex_to_7seg u_dec (
      .nibble  (nibble),
      .pattern (pattern)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt        <= '0;
         idx        <= '0;
         sh_value   <= '0;
         sh_dp      <= '0;
         sh_en      <= '0;
         pending    <= 1'b0;
         ca         <= CA_OFF;
         seg        <= SEG_OFF;
         seg_dp     <= SEG_ACTIVE_LOW;
         frame_tick <= 1'b0;
      end else begin
         if (cnt == CNT_LAST) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
         end else begin
            cnt <= cnt + 1'b1;
         end
         frame_tick <= (cnt == CNT_LAST) && (idx == IDX_LAST);

         // Shadow capture only on the frame-start cycle, which sits in the blank interval.
         if (frame_tick && (pending || update)) begin
            sh_value <= value;
            sh_dp    <= dp;
            sh_en    <= digit_en;
            pending  <= 1'b0;
         end else if (update) begin
            pending  <= 1'b1;
         end

         ca     <= lit ? (onehot ^ CA_OFF) : CA_OFF;
         seg    <= lit ? (pattern ^ SEG_OFF) : SEG_OFF;
         seg_dp <= (lit && dp_sel) ^ SEG_ACTIVE_LOW;
      end
   end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Randomised scoreboard bench for seven_seg_scanner against a slot/frame
// arithmetic model of the display.
module tb_seven_seg_scanner;

   localparam int ND    = 3;
   localparam int SD    = 64;
   localparam int BC    = 16;
   localparam int ON    = 3;
   localparam int FRAME = ND * SD;

   logic        clk = 1'b0;
   logic        reset;
   logic [11:0] value;
   logic [2:0]  dp;
   logic [2:0]  digit_en;
   logic        lz_suppress;
   logic [3:0]  brightness;
   logic        update;
   logic [2:0]  ca;
   logic [6:0]  seg;
   logic        seg_dp;
   logic        frame_tick;

   always #5 clk = ~clk;

   seven_seg_scanner #(
      .NUM_DIGITS     (ND),
      .SCAN_DIV       (SD),
      .BLANK_CYCLES   (BC),
      .CA_ACTIVE_LOW  (1'b1),
      .SEG_ACTIVE_LOW (1'b1)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .value       (value),
      .dp          (dp),
      .digit_en    (digit_en),
      .lz_suppress (lz_suppress),
      .brightness  (brightness),
      .update      (update),
      .ca          (ca),
      .seg         (seg),
      .seg_dp      (seg_dp),
      .frame_tick  (frame_tick)
   );

   typedef struct packed {
      logic [2:0] ca;
      logic [6:0] seg;
      logic       dp;
      logic       ft;
   } exp_t;

   exp_t sb[$];
   int   vectors     = 0;
   int   miscompares = 0;

   logic [6:0] glyph [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   // Reference state: t counts cycles since reset release (t=0 is digit 0, count 0).
   int          t      = 0;
   logic [11:0] m_val  = '0;
   logic [2:0]  m_dp   = '0;
   logic [2:0]  m_en   = '0;
   bit          m_pend = 1'b0;

   // Predict the output seen in the next cycle from this cycle's state and inputs.
   task automatic cycle();
      exp_t       e;
      int         cnt;
      int         idx;
      logic [3:0] nib;
      bit         lit;
      bit         fs;
      e = '{ca: 3'b111, seg: 7'h7F, dp: 1'b1, ft: 1'b0};
      if (reset) begin
         t = 0; m_val = '0; m_dp = '0; m_en = '0; m_pend = 1'b0;
      end else begin
         cnt = t % SD;
         idx = (t / SD) % ND;
         nib = 4'((m_val >> (4 * idx)) & 12'hF);
         lit = (cnt >= BC) && (cnt < BC + (int'(brightness) + 1) * ON) && m_en[idx] &&
               !(idx > 0 && lz_suppress && ((m_val >> (4 * idx)) == 12'h0));
         if (lit) begin
            e.ca  = 3'b111 & ~(3'b001 << idx);
            e.seg = ~glyph[nib];
            e.dp  = ~m_dp[idx];
         end
         e.ft = ((t + 1) % FRAME == 0);
         fs = (t > 0) && (t % FRAME == 0);
         if (fs && (m_pend || update)) begin
            m_val = value; m_dp = dp; m_en = digit_en; m_pend = 1'b0;
         end else if (update) begin
            m_pend = 1'b1;
         end
         t++;
      end
      @(posedge clk);
      #1;
      sb.push_back(e);
   endtask

   task automatic pulse_update();
      update = 1'b1;
      cycle();
      update = 1'b0;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            vectors++;
            if ({ca, seg, seg_dp, frame_tick} !== e) begin
               miscompares++;
               $display("FAIL scan @%0t: got ca=%b seg=%h dp=%b ft=%b, want ca=%b seg=%h dp=%b ft=%b",
                        $time, ca, seg, seg_dp, frame_tick, e.ca, e.seg, e.dp, e.ft);
            end
            vectors++;
            if ($countones(~ca) > 1) begin
               miscompares++;
               $display("FAIL one_anode @%0t: got ca=%b, want at most one low bit", $time, ca);
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1);
   end

   initial begin : stimulus
      reset = 1'b1; update = 1'b0; lz_suppress = 1'b0; value = '0;
      dp = '0; digit_en = '0; brightness = 4'd15;
      repeat (3) cycle();
      reset = 1'b0;
      repeat (200) cycle();

      value = 12'h1A5; dp = 3'b010; digit_en = 3'b111;
      pulse_update();
      repeat (2 * FRAME) cycle();
      brightness = 4'd0;
      repeat (FRAME) cycle();
      brightness = 4'd7;
      repeat (FRAME) cycle();
      brightness = 4'd15;

      lz_suppress = 1'b1; value = 12'h005;
      pulse_update();
      repeat (2 * FRAME) cycle();
      value = 12'h000;
      pulse_update();
      repeat (2 * FRAME) cycle();
      lz_suppress = 1'b0;
      repeat (FRAME) cycle();

      value = 12'h1A5;
      pulse_update();
      repeat (2 * FRAME) cycle();
      value = 12'h777;
      while (!(((t / SD) % ND == 1) && (t % SD == 20))) cycle();
      pulse_update();
      repeat (2 * FRAME) cycle();

      value = 12'h3C9; dp = 3'b101;
      while (!((t > 0) && (t % FRAME == 0))) cycle();
      pulse_update();
      value = 12'hBEE;
      repeat (FRAME) cycle();

      repeat (10 * FRAME) begin
         if ($urandom_range(0, 31) == 0) brightness = 4'($urandom);
         if ($urandom_range(0, 63) == 0) digit_en = 3'($urandom);
         if ($urandom_range(0, 127) == 0) lz_suppress = 1'($urandom);
         value  = 12'($urandom);
         dp     = 3'($urandom);
         update = ($urandom_range(0, 99) == 0);
         cycle();
      end
      update = 1'b0;

      while (t % SD != 30) cycle();
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      value = 12'h1A5; dp = 3'b010; digit_en = 3'b111; brightness = 4'd9;
      pulse_update();
      repeat (2 * FRAME + 20) cycle();

      @(negedge clk);
      #1;
      vectors++;
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL drain: got %0d pending expectations, want 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
